fpu_result_queue: RTL and testbench
===================================

Name: fpu_result_queue

Overview:
- Downstream stage of fpu_top. Captures every FPU result word, its 5-bit exception flags and an operation tag into a first-word-fall-through (FWFT) FIFO, so the management SoC can drain results over wishbone or LA at its own pace.
- Accumulates RISC-V style sticky fflags and raises one level interrupt on fill threshold, unmasked exception or overflow.
- Replaces the single-result capture path when operations are issued back-to-back.

Parameters:
- DEPTH, 8, number of entries; power of two, 2..32.
- IRQ_THRESH, 4, entry count at or above which the threshold interrupt asserts; 1..DEPTH.

Ports:
- clk  in  1  core clock
- rst_l  in  1  asynchronous active-low reset
- res_valid  in  1  one-cycle pulse: result present on res_* this cycle
- res_data  in  32  FPU result word
- res_exc  in  5  exception flags {NV,DZ,OF,UF,NX}
- res_tag  in  4  operation index 0..10 (fclass..sqrt), 15 = illegal op
- pop  in  1  remove head entry
- flags_clr  in  1  clear sticky fflags and overflow
- exc_mask  in  5  1 = corresponding flag may raise irq
- head_data  out  32  head entry data (FWFT)
- head_exc  out  5  head entry flags
- head_tag  out  4  head entry tag
- empty  out  1  queue empty
- full  out  1  queue full
- count  out  $clog2(DEPTH)+1  occupied entries
- fflags  out  5  sticky OR of flags of accepted entries
- overflow  out  1  sticky: a push was dropped
- underflow  out  1  sticky: pop seen while empty
- irq  out  1  level interrupt

Behaviour:
- Storage: DEPTH x 41-bit entries {tag, exc, data}; write pointer, read pointer and count registers. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Reset (rst_l low, async): pointers=0, count=0, fflags=0, overflow=0, underflow=0, irq=0, empty=1, full=0, head_* = 0. Storage contents need not be reset; head_* is forced to 0 whenever empty.
- Push = res_valid & (~full | pop_eff). Pop_eff = pop & ~empty.
- Push writes at wptr on the clock edge; entry is visible on head_* the next cycle if the queue was empty. Latency from push to head is 1 cycle.
- Pop_eff advances rptr; the next entry appears on head_* the following cycle.
- Count update: +1 on push only, -1 on pop_eff only, unchanged when both or neither occur.
- full = (count==DEPTH); empty = (count==0); both are decoded from registered count.
- Full with simultaneous pop and res_valid: both take effect, count stays DEPTH, no overflow.
- Full, res_valid, no pop: entry dropped; overflow<=1; fflags not updated.
- Empty with pop: ignored; underflow<=1. Empty with pop and res_valid together: push accepted, pop ignored, underflow<=1.
- fflags <= fflags | res_exc on accepted push.
- flags_clr clears fflags, overflow and underflow. If flags_clr coincides with an accepted push, fflags <= res_exc (the new entry is not lost). If it coincides with a dropped push, overflow <= 1.
- flags_clr does not affect queue contents.
- irq (registered, 1-cycle latency) = (count_next >= IRQ_THRESH) | |(fflags_next & exc_mask) | overflow_next.
- Reset deasserting mid-traffic: a res_valid in the first cycle after release is accepted normally.

Test Plan:
- Reset, then push data 0x3F800000, exc 0, tag 6. Next cycle: head_data=0x3F800000, head_tag=6, count=1, empty=0, irq=0. Pop, then next cycle: empty=1, head_data=0.
- Push 8 entries with data 0..7. Result: full=1, count=8. A 9th push gives overflow=1 and the entry is dropped. Pop 8 times: head reads 0..7 in order, and rptr wraps correctly on the second fill.
- With full, assert pop and res_valid (data 0xAA) in the same cycle. Result: count stays 8, overflow=0, and 0xAA is read last after draining.
- Push exc 5'b10000, then push exc 5'b00001. Result: fflags=5'b10001. With exc_mask=5'b00001: irq=1. Apply flags_clr together with a push of exc 5'b00100: fflags=5'b00100, irq=0.
- Pop while empty gives underflow=1 with count unchanged. Push IRQ_THRESH=4 entries with exc 0: irq rises the cycle after the 4th push and falls the cycle after the first pop.
- Assert rst_l low asynchronously, mid-cycle, with count=5: count=0, empty=1, irq=0 and fflags=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fpu_result_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : fpu_result_queue_if
// Description : Result-capture and head-drain bundle for fpu_result_queue.
//               The master side issues FPU results and pops entries. The slave
//               side (the queue) presents the FWFT head entry and the
//               occupancy status.
// Revision    : 1.0 - initial release
// ============================================================================
interface fpu_result_queue_if #(
   parameter int DEPTH = 8
);
   localparam int c_cnt_w = $clog2(DEPTH) + 1;

   // producer side: one-cycle result pulse from the FPU
   logic               res_valid;
   logic [31:0]        res_data;
   logic [4:0]         res_exc;
   logic [3:0]         res_tag;

   // consumer side: FWFT head entry and pop request
   logic               pop;
   logic [31:0]        head_data;
   logic [4:0]         head_exc;
   logic [3:0]         head_tag;
   logic               empty;
   logic               full;
   logic [c_cnt_w-1:0] count;

   modport master (
      output res_valid, res_data, res_exc, res_tag, pop,
      input  head_data, head_exc, head_tag, empty, full, count
   );

   modport slave (
      input  res_valid, res_data, res_exc, res_tag, pop,
      output head_data, head_exc, head_tag, empty, full, count
   );
endinterface
`default_nettype wire

// File: rtl/fpu_result_queue.sv
`default_nettype none
// ============================================================================
// Module      : fpu_result_queue
// Description : FWFT result FIFO behind fpu_top. Holds {tag, exc, data} per
//               FPU result. Keeps sticky RISC-V fflags, overflow and underflow
//               status, and drives one registered level interrupt on fill
//               threshold, unmasked exception or overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_result_queue #(
   parameter int DEPTH      = 8,
   parameter int IRQ_THRESH = 4
) (
   input  logic                  clk,
   input  logic                  rst_l,
   fpu_result_queue_if.slave     q,
   input  logic                  flags_clr,
   input  logic [4:0]            exc_mask,
   output logic [4:0]            fflags,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  irq
);
   localparam int                 c_ptr_w  = $clog2(DEPTH);
   localparam int                 c_cnt_w  = c_ptr_w + 1;
   localparam logic [c_cnt_w-1:0] c_depth  = c_cnt_w'(DEPTH);
   localparam logic [c_cnt_w-1:0] c_thresh = c_cnt_w'(IRQ_THRESH);

   // Entry layout: [40:37] tag, [36:32] exc, [31:0] data
   logic [40:0]        r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_wptr;
   logic [c_ptr_w-1:0] r_rptr;
   logic [c_cnt_w-1:0] r_count;
   logic [4:0]         r_fflags;
   logic               r_overflow;
   logic               r_underflow;
   logic               r_irq;

   logic               w_empty;
   logic               w_full;
   logic               w_pop_eff;
   logic               w_push;
   logic               w_drop;
   logic               w_pop_empty;
   logic [c_cnt_w-1:0] w_count_next;
   logic [4:0]         w_fflags_next;
   logic               w_overflow_next;
   logic               w_underflow_next;
   logic               w_irq_next;
   logic [40:0]        w_head;

   // Handshake decode and next-state values for count, sticky flags and irq
   always_comb begin
      w_empty     = (r_count == '0);
      w_full      = (r_count == c_depth);
      w_pop_eff   = q.pop & ~w_empty;
      // a pop in the same cycle frees the slot, so a full queue still accepts
      w_push      = q.res_valid & (~w_full | w_pop_eff);
      w_drop      = q.res_valid & ~w_push;
      w_pop_empty = q.pop & w_empty;

      case ({w_push, w_pop_eff})
         2'b10:   w_count_next = r_count + 1'b1;
         2'b01:   w_count_next = r_count - 1'b1;
         default: w_count_next = r_count;
      endcase

      // a clear never discards the flags of the entry accepted alongside it
      if (flags_clr) begin
         w_fflags_next    = w_push ? q.res_exc : 5'b0;
         w_overflow_next  = w_drop;
         w_underflow_next = w_pop_empty;
      end else begin
         w_fflags_next    = w_push ? (r_fflags | q.res_exc) : r_fflags;
         w_overflow_next  = r_overflow | w_drop;
         w_underflow_next = r_underflow | w_pop_empty;
      end

      w_irq_next = (w_count_next >= c_thresh)
                 | (|(w_fflags_next & exc_mask))
                 | w_overflow_next;
   end

   // Entry storage: written on accepted push, contents are not reset
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= {q.res_tag, q.res_exc, q.res_data};
      end
   end

   // Pointers, occupancy, sticky status and interrupt register
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_fflags    <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
         r_irq       <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop_eff) begin
            r_rptr <= r_rptr + 1'b1;
         end
         r_count     <= w_count_next;
         r_fflags    <= w_fflags_next;
         r_overflow  <= w_overflow_next;
         r_underflow <= w_underflow_next;
         r_irq       <= w_irq_next;
      end
   end

   // FWFT head: gated to zero while empty so reset clears it without a clock
   always_comb begin
      w_head      = r_mem[r_rptr];
      q.head_data = w_empty ? 32'b0 : w_head[31:0];
      q.head_exc  = w_empty ? 5'b0  : w_head[36:32];
      q.head_tag  = w_empty ? 4'b0  : w_head[40:37];
      q.empty     = w_empty;
      q.full      = w_full;
      q.count     = r_count;
   end

   assign fflags    = r_fflags;
   assign overflow  = r_overflow;
   assign underflow = r_underflow;
   assign irq       = r_irq;
endmodule
`default_nettype wire

// File: tb/tb_fpu_result_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_result_queue
// Description : Self-checking bench for fpu_result_queue. Runs directed steps
//               and then random traffic. Every cycle is compared against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_result_queue;
   localparam int DEPTH      = 8;
   localparam int IRQ_THRESH = 4;

   logic       clk;
   logic       rst_l;
   logic       flags_clr;
   logic [4:0] exc_mask;
   logic [4:0] fflags;
   logic       overflow;
   logic       underflow;
   logic       irq;

   fpu_result_queue_if #(.DEPTH(DEPTH)) ifc ();

   fpu_result_queue #(.DEPTH(DEPTH), .IRQ_THRESH(IRQ_THRESH)) dut (
      .clk       (clk),
      .rst_l     (rst_l),
      .q         (ifc.slave),
      .flags_clr (flags_clr),
      .exc_mask  (exc_mask),
      .fflags    (fflags),
      .overflow  (overflow),
      .underflow (underflow),
      .irq       (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state
   logic [40:0] mq[$];
   logic [4:0]  m_fflags;
   logic        m_ovf;
   logic        m_unf;
   logic        m_irq;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [40:0] h;
      h = (mq.size() > 0) ? mq[0] : 41'b0;
      chk("head_data", 64'(ifc.head_data), 64'(h[31:0]));
      chk("head_exc",  64'(ifc.head_exc),  64'(h[36:32]));
      chk("head_tag",  64'(ifc.head_tag),  64'(h[40:37]));
      chk("count",     64'(ifc.count),     64'(mq.size()));
      chk("empty",     64'(ifc.empty),     64'(mq.size() == 0));
      chk("full",      64'(ifc.full),      64'(mq.size() == DEPTH));
      chk("fflags",    64'(fflags),        64'(m_fflags));
      chk("overflow",  64'(overflow),      64'(m_ovf));
      chk("underflow", 64'(underflow),     64'(m_unf));
      chk("irq",       64'(irq),           64'(m_irq));
   endtask

   task automatic model_reset();
      mq.delete();
      m_fflags = 5'b0;
      m_ovf    = 1'b0;
      m_unf    = 1'b0;
      m_irq    = 1'b0;
   endtask

   // one clock cycle of stimulus; the model follows the queue rules directly
   task automatic cyc(input logic v, input logic [31:0] d, input logic [4:0] e,
                      input logic [3:0] t, input logic p, input logic c);
      bit pe, ps, drop, und;
      ifc.res_valid = v;
      ifc.res_data  = d;
      ifc.res_exc   = e;
      ifc.res_tag   = t;
      ifc.pop       = p;
      flags_clr     = c;
      pe   = p && (mq.size() > 0);
      ps   = v && ((mq.size() < DEPTH) || pe);
      drop = v && !ps;
      und  = p && (mq.size() == 0);
      @(posedge clk);
      #1;
      if (pe) void'(mq.pop_front());
      if (ps) mq.push_back({t, e, d});
      if (c) begin
         m_fflags = ps ? e : 5'b0;
         m_ovf    = drop;
         m_unf    = und;
      end else begin
         if (ps) m_fflags = m_fflags | e;
         m_ovf = m_ovf | drop;
         m_unf = m_unf | und;
      end
      m_irq = (mq.size() >= IRQ_THRESH) || ((m_fflags & exc_mask) != 5'b0) || m_ovf;
      ifc.res_valid = 1'b0;
      ifc.pop       = 1'b0;
      flags_clr     = 1'b0;
      check_all();
   endtask

   task automatic idle();
      cyc(1'b0, 32'h0, 5'h0, 4'h0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [31:0] rd;
      logic [4:0]  re;
      logic [3:0]  rt;
      rst_l         = 1'b0;
      ifc.res_valid = 1'b0;
      ifc.res_data  = '0;
      ifc.res_exc   = '0;
      ifc.res_tag   = '0;
      ifc.pop       = 1'b0;
      flags_clr     = 1'b0;
      exc_mask      = 5'b0;
      model_reset();

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check_all();
      #4 rst_l = 1'b1;

      // single push and pop, 1-cycle head latency
      cyc(1'b1, 32'h3F80_0000, 5'h00, 4'd6, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 5'h0, 4'h0, 1'b1, 1'b0);

      // fill to full (write pointer wraps), drop a 9th push, then drain
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'(i), 5'h0, 4'(i % 11), 1'b0, 1'b0);
      cyc(1'b1, 32'hDEAD, 5'h1F, 4'd15, 1'b0, 1'b0);
      for (int i = 0; i < DEPTH; i++) cyc(1'b0, 32'h0, 5'h0, 4'h0, 1'b1, 1'b0);

      // clear, refill, simultaneous push and pop while full, then drain
      cyc(1'b0, 32'h0, 5'h0, 4'h0, 1'b0, 1'b1);
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'(100 + i), 5'h0, 4'd1, 1'b0, 1'b0);
      cyc(1'b1, 32'hAA, 5'h0, 4'd2, 1'b1, 1'b0);
      for (int i = 0; i < DEPTH; i++) cyc(1'b0, 32'h0, 5'h0, 4'h0, 1'b1, 1'b0);

      // sticky flags, masked irq and clear together with a push
      exc_mask = 5'b00001;
      cyc(1'b1, 32'h1, 5'b10000, 4'd3, 1'b0, 1'b0);
      cyc(1'b1, 32'h2, 5'b00001, 4'd4, 1'b0, 1'b0);
      cyc(1'b1, 32'h3, 5'b00100, 4'd5, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 5'h0, 4'h0, 1'b1, 1'b0);
      exc_mask = 5'b0;

      // underflow, then threshold irq rise and fall
      cyc(1'b0, 32'h0, 5'h0, 4'h0, 1'b1, 1'b0);
      cyc(1'b1, 32'h55, 5'h0, 4'd7, 1'b1, 1'b0);
      cyc(1'b0, 32'h0, 5'h0, 4'h0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cyc(1'b1, 32'(200 + i), 5'h0, 4'd8, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 5'h0, 4'h0, 1'b1, 1'b0);
      idle();

      // asynchronous reset mid-cycle with five entries held
      for (int i = 0; i < 2; i++) cyc(1'b1, 32'(300 + i), 5'h02, 4'd9, 1'b0, 1'b0);
      #2 rst_l = 1'b0;
      #1;
      model_reset();
      check_all();
      #1 rst_l = 1'b1;
      cyc(1'b1, 32'h1234_5678, 5'h08, 4'd10, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 5'h0, 4'h0, 1'b1, 1'b0);

      // randomized traffic
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 49) == 0) exc_mask = 5'($urandom);
         rd = $urandom;
         re = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
         rt = ($urandom_range(0, 11) == 11) ? 4'd15 : 4'($urandom_range(0, 10));
         cyc($urandom_range(0, 99) < 55, rd, re, rt,
             $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 4);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
